uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Parametrised full-duplex UART; successor to the fixed 8N1 UART.
- Configurable data width, parity, stop bits and RX oversampling.
- Valid/ready handshakes on both sides, plus per-word error flags.
- Sits between the CPU bus bridge and the board serial pins.

Parameters:
CLOCK_RATE, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, TX stop bits, legal 1 or 2
OVERSAMPLE, 16, baud ticks per bit, even, legal 8..16

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  DATA_BITS  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  transmitter can accept a word
tx  output  1  serial out, idles high
tx_busy  output  1  frame in progress on tx
rx  input  1  serial in, asynchronous
rx_data  output  DATA_BITS  received word
rx_valid  output  1  rx_data and error flags valid
rx_ready  input  1  consumer accepts rx_data
rx_frame_err  output  1  stop bit sampled low for the word held
rx_parity_err  output  1  parity mismatch for the word held (0 when PARITY = 0)
rx_overrun  output  1  at least one word dropped since the last accept

Behaviour:
- Reset: synchronous and active-high, dominates all other inputs, takes effect mid-frame.
- Reset values: tx = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, all error flags = 0, rx_data = 0, tick counter = 0, both FSMs = IDLE.
- Tick generator: DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE), integer, minimum 1.
  - Free-running counter emits a one-cycle tick when it reaches DIV - 1, then wraps to 0.
  - One bit period = OVERSAMPLE ticks.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - tx_ready = 1 only in IDLE.
  - A word is accepted on the cycle tx_valid && tx_ready; tx_data is latched.
  - tx_ready falls and tx_busy rises on the next cycle.
  - The start bit begins on the next tick.
  - Parity bit = XOR of the data bits, inverted for odd parity.
  - STOP drives 1 for STOP_BITS bit periods; the FSM then returns to IDLE with tx_ready = 1.
  - tx_valid held high gives back-to-back frames with no idle gap beyond tick alignment.
  - tx_data changes after acceptance have no effect on the frame in flight.
- RX synchroniser: two flops on rx; all RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a low sample on a tick starts the sample counter.
  - START: at OVERSAMPLE/2 ticks, re-check the line. High = false start, return to IDLE. Low = go to DATA.
  - DATA/PARITY/STOP: sample once per bit, every OVERSAMPLE ticks, at mid-bit. Data is shifted in LSB first.
  - RX checks only the first stop bit, whatever STOP_BITS is set to.
- RX word completion, at the stop-bit sample:
  - If rx_valid = 0: load rx_data, rx_frame_err and rx_parity_err, and set rx_valid on the next cycle.
  - If rx_valid = 1: discard the new word, leave the held word unchanged, set rx_overrun (sticky).
- RX handshake:
  - rx_valid && rx_ready clears rx_valid and rx_overrun on the next cycle.
  - A completion in the same cycle as the accept is loaded, with the overrun flag left clear.
- Break/frame error: if the stop bit is sampled low, the FSM waits in STOP until the line is high before returning to IDLE. A held-low line therefore yields exactly one word, with rx_frame_err = 1.
- Parameter checks: an illegal parameter value triggers an elaboration-time $error.

Optional Feature:
- Macro: UART_CORE_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback = 1, the RX synchroniser input is the internal tx signal instead of rx, and the tx pin is held at 1.
  - Switching loopback mid-frame is allowed; any garbage word produced is flagged normally.
- Undefined: no port, RX always uses rx, zero added logic.

Test Plan:
- Setup: CLOCK_RATE 1_600_000, BAUD_RATE 100_000, OVERSAMPLE 16, so DIV = 1 and one bit = 16 clocks.
1. 8N1, send 0xA5 -> tx shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 16 clocks. tx_ready is low from the accept cycle + 1 until the frame ends.
2. 7E2 (DATA_BITS 7, PARITY 2, STOP_BITS 2), RX word 0x41 with correct parity -> rx_data = 0x41, rx_valid = 1, both error flags 0. Repeat with the parity bit flipped -> rx_parity_err = 1.
3. rx glitch low for 5 clocks in IDLE -> no rx_valid; a following valid 0x3C frame is received correctly.
4. Two frames 0x11 and 0x22 with rx_ready held 0 -> rx_data = 0x11 and rx_overrun = 1; asserting rx_ready clears both rx_valid and rx_overrun.
5. rx held low for 30 bit periods -> exactly one word, 0x00, with rx_frame_err = 1. After rx returns high, a 0x5A frame is received cleanly.
6. Reset asserted mid-TX at data bit 3 -> tx = 1 and tx_ready = 1 on the next cycle. With UART_CORE_LOOPBACK_EN and loopback = 1, sending 0xC3 -> rx_data = 0xC3 and tx pin stays 1.

Source files
------------

// File: rtl/uart_core_if.sv
// Word-level handshake bundle between the UART core and its bus-side user.
// master = bus bridge side, slave = uart_core.
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with oversampled RX and per-word error flags.
// Optional macro UART_CORE_LOOPBACK_EN adds a loopback port routing tx into the RX path.
module uart_core #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    uart_core_if.slave bus,
    output logic       tx,
    input  logic       rx
`ifdef UART_CORE_LOOPBACK_EN
    , input logic      loopback
`endif
);
    localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OSW     = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic           PAR_ODD  = (PARITY == 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_core: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_core: OVERSAMPLE must be even and 8..16");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    logic [CW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    state_t               tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [OSW-1:0]       tx_os;
    logic [3:0]           tx_bit;
    logic                 tx_stop;
    logic                 tx_par;
    logic                 tx_line;
    logic                 tx_level;

    always_comb begin
        tx_level = 1'b1;
        case (tx_state)
            S_START:  tx_level = 1'b0;
            S_DATA:   tx_level = tx_shift[0];
            S_PARITY: tx_level = tx_par;
            default:  tx_level = 1'b1;
        endcase
    end

    // Each bit is driven on the first tick of its period and held for OVERSAMPLE ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state     <= S_IDLE;
            tx_shift     <= '0;
            tx_os        <= '0;
            tx_bit       <= '0;
            tx_stop      <= 1'b0;
            tx_par       <= 1'b0;
            tx_line      <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.tx_busy  <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (bus.tx_valid) begin
                tx_shift     <= bus.tx_data;
                tx_par       <= (^bus.tx_data) ^ PAR_ODD;
                tx_os        <= '0;
                tx_bit       <= '0;
                tx_stop      <= 1'b0;
                tx_state     <= S_START;
                bus.tx_ready <= 1'b0;
                bus.tx_busy  <= 1'b1;
            end
        end else if (tick) begin
            if (tx_os == '0) tx_line <= tx_level;
            if (tx_os != OS_LAST) begin
                tx_os <= tx_os + 1'b1;
            end else begin
                tx_os <= '0;
                case (tx_state)
                    S_START: tx_state <= S_DATA;
                    S_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == BIT_LAST) tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                    S_PARITY: tx_state <= S_STOP;
                    default: begin
                        tx_stop <= tx_stop + 1'b1;
                        if (tx_stop == 1'(STOP_BITS - 1)) begin
                            tx_state     <= S_IDLE;
                            bus.tx_ready <= 1'b1;
                            bus.tx_busy  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    logic rx_src;
`ifdef UART_CORE_LOOPBACK_EN
    assign rx_src = loopback ? tx_line : rx;
    assign tx     = loopback ? 1'b1 : tx_line;
`else
    assign rx_src = rx;
    assign tx     = tx_line;
`endif

    logic rx_s1, rx_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_in <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_in <= rx_s1;
        end
    end

    state_t               rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic [OSW-1:0]       rx_os;
    logic [3:0]           rx_bit;
    logic                 rx_perr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state          <= S_IDLE;
            rx_shift          <= '0;
            rx_os             <= '0;
            rx_bit            <= '0;
            rx_perr           <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else begin
            if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid   <= 1'b0;
                bus.rx_overrun <= 1'b0;
            end
            case (rx_state)
                S_IDLE: if (tick && !rx_in) begin
                    rx_os    <= '0;
                    rx_state <= S_START;
                end
                S_START: if (tick) begin
                    if (rx_os == OS_MID) begin
                        rx_os    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_in ? S_IDLE : S_DATA;
                    end else begin
                        rx_os <= rx_os + 1'b1;
                    end
                end
                S_DATA, S_PARITY, S_STOP: if (tick) begin
                    if (rx_os != OS_LAST) begin
                        rx_os <= rx_os + 1'b1;
                    end else begin
                        rx_os <= '0;
                        if (rx_state == S_DATA) begin
                            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 1'b1;
                            if (rx_bit == BIT_LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else if (rx_state == S_PARITY) begin
                            rx_perr  <= (^rx_shift) ^ rx_in ^ PAR_ODD;
                            rx_state <= S_STOP;
                        end else begin
                            // A word completing in the same cycle as an accept is kept.
                            if (!bus.rx_valid || bus.rx_ready) begin
                                bus.rx_data       <= rx_shift;
                                bus.rx_frame_err  <= !rx_in;
                                bus.rx_parity_err <= rx_perr;
                                bus.rx_valid      <= 1'b1;
                            end else begin
                                bus.rx_overrun <= 1'b1;
                            end
                            rx_state <= rx_in ? S_IDLE : S_WAIT;
                        end
                    end
                end
                default: if (rx_in) rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: 8N1 and 7E2 instances at DIV = 1 (16 clocks per bit),
// compared against a frame model built from data, parity and stop-bit rules.
module tb_uart_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx8 = 1'b1, rx7 = 1'b1;
    logic tx8, tx7;
`ifdef UART_CORE_LOOPBACK_EN
    logic lb8 = 1'b0;
    logic lb7 = 1'b0;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_core_if #(.DATA_BITS(8)) b8();
    uart_core_if #(.DATA_BITS(7)) b7();

    uart_core #(.CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(16)) u8 (
        .clock (clk),
        .reset (rst),
        .bus   (b8),
        .tx    (tx8),
        .rx    (rx8)
`ifdef UART_CORE_LOOPBACK_EN
        , .loopback(lb8)
`endif
    );

    uart_core #(.CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .OVERSAMPLE(16)) u7 (
        .clock (clk),
        .reset (rst),
        .bus   (b7),
        .tx    (tx7),
        .rx    (rx7)
`ifdef UART_CORE_LOOPBACK_EN
        , .loopback(lb7)
`endif
    );

    // Line level for each bit period of a frame: start, data LSB first, parity, stop(s).
    function automatic logic [15:0] frame_bits(input int data, input int nbits, input int par);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nbits; i++) f[1 + i] = ((data >> i) & 1) != 0;
        if (par != 0) begin
            ones = $countones(data & ((1 << nbits) - 1));
            f[1 + nbits] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        end
        return f;
    endfunction

    task automatic rx_send(input int which, input int d, input bit flip_par);
        logic [15:0] fb;
        int n;
        if (which == 8) begin
            fb = frame_bits(d, 8, 0);
            n  = 10;
        end else begin
            fb = frame_bits(d, 7, 2);
            if (flip_par) fb[8] = ~fb[8];
            n  = 11;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (which == 8) rx8 = fb[k]; else rx7 = fb[k];
            repeat (15) @(negedge clk);
        end
    endtask

    task automatic wait_rx8();
        int t = 0;
        while (b8.rx_valid !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
    endtask

    task automatic accept8();
        @(negedge clk); b8.rx_ready = 1'b1;
        @(posedge clk); #1; b8.rx_ready = 1'b0;
    endtask

    // Sends one byte on u8 and checks every bit period at mid-bit plus the ready/busy timing.
    task automatic tx_frame_check(input logic [7:0] d);
        logic [15:0] fb;
        int t;
        fb = frame_bits(d, 8, 0);
        t = 0;
        while (b8.tx_ready !== 1'b1 && t < 400) begin @(posedge clk); #1; t++; end
        @(negedge clk); b8.tx_data = d; b8.tx_valid = 1'b1;
        @(posedge clk); #1; b8.tx_valid = 1'b0; b8.tx_data = ~d;
        n_checks++; if (b8.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_fall got %b want 0", b8.tx_ready); end
        n_checks++; if (b8.tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_rise got %b want 1", b8.tx_busy); end
        repeat (9) @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (tx8 !== fb[k]) begin n_fail++; $display("FAIL tx_bit%0d data=%h got %b want %b", k, d, tx8, fb[k]); end
            n_checks++;
            if (b8.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_in_frame bit%0d got %b want 0", k, b8.tx_ready); end
            if (k < 9) begin repeat (16) @(posedge clk); #1; end
        end
        t = 0;
        while (b8.tx_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        n_checks++; if (b8.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_end got %b want 1", b8.tx_ready); end
        n_checks++; if (b8.tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_busy_end got %b want 0", b8.tx_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (tx8 !== 1'b1) begin n_fail++; $display("FAIL rst_tx8 got %b want 1", tx8); end
        n_checks++; if (tx7 !== 1'b1) begin n_fail++; $display("FAIL rst_tx7 got %b want 1", tx7); end
        n_checks++; if (b8.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready got %b want 1", b8.tx_ready); end
        n_checks++; if (b8.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy got %b want 0", b8.tx_busy); end
        n_checks++; if (b8.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid got %b want 0", b8.rx_valid); end
        n_checks++; if (b8.rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data got %h want 00", b8.rx_data); end
        n_checks++; if ({b8.rx_frame_err, b8.rx_parity_err, b8.rx_overrun} !== 3'b000) begin
            n_fail++; $display("FAIL rst_err8 got %b want 000", {b8.rx_frame_err, b8.rx_parity_err, b8.rx_overrun}); end
        n_checks++; if ({b7.rx_valid, b7.rx_frame_err, b7.rx_parity_err, b7.rx_overrun} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags7 got %b want 0000", {b7.rx_valid, b7.rx_frame_err, b7.rx_parity_err, b7.rx_overrun}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_tx();
        tx_frame_check(8'hA5);
        for (int i = 0; i < 3; i++) tx_frame_check(8'($urandom_range(0, 255)));
    endtask

    task automatic test_rx_parity();
        int d, t;
        bit fl;
        for (int i = 0; i < 6; i++) begin
            d  = (i < 2) ? 'h41 : int'($urandom_range(0, 127));
            fl = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rx_send(7, d, fl);
            t = 0;
            while (b7.rx_valid !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
            n_checks++; if (b7.rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx7_valid word=%h got %b want 1", d, b7.rx_valid); end
            n_checks++; if (b7.rx_data !== 7'(d)) begin n_fail++; $display("FAIL rx7_data got %h want %h", b7.rx_data, 7'(d)); end
            n_checks++; if (b7.rx_parity_err !== fl) begin n_fail++; $display("FAIL rx7_parity_err word=%h got %b want %b", d, b7.rx_parity_err, fl); end
            n_checks++; if (b7.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL rx7_frame_err got %b want 0", b7.rx_frame_err); end
            @(negedge clk); b7.rx_ready = 1'b1;
            @(posedge clk); #1; b7.rx_ready = 1'b0;
            n_checks++; if (b7.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx7_accept got %b want 0", b7.rx_valid); end
        end
    endtask

    task automatic test_glitch();
        @(negedge clk); rx8 = 1'b0;
        repeat (5) @(negedge clk); rx8 = 1'b1;
        repeat (200) @(posedge clk); #1;
        n_checks++; if (b8.rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_word got %b want 0", b8.rx_valid); end
        rx_send(8, 'h3C, 1'b0);
        wait_rx8();
        n_checks++; if (b8.rx_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_valid got %b want 1", b8.rx_valid); end
        n_checks++; if (b8.rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_data got %h want 3c", b8.rx_data); end
        n_checks++; if (b8.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr got %b want 0", b8.rx_frame_err); end
        accept8();
    endtask

    task automatic test_overrun();
        int d1, d2;
        d1 = 'h11;
        d2 = 'h22;
        for (int i = 0; i < 2; i++) begin
            rx_send(8, d1, 1'b0);
            rx_send(8, d2, 1'b0);
            repeat (4) @(posedge clk); #1;
            n_checks++; if (b8.rx_data !== 8'(d1)) begin n_fail++; $display("FAIL ovr_data got %h want %h", b8.rx_data, 8'(d1)); end
            n_checks++; if (b8.rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", b8.rx_overrun); end
            n_checks++; if (b8.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", b8.rx_valid); end
            accept8();
            n_checks++; if ({b8.rx_valid, b8.rx_overrun} !== 2'b00) begin
                n_fail++; $display("FAIL ovr_clear got %b want 00", {b8.rx_valid, b8.rx_overrun}); end
            d1 = int'($urandom_range(0, 255));
            d2 = int'($urandom_range(0, 255));
        end
    endtask

    task automatic test_break();
        @(negedge clk); rx8 = 1'b0;
        repeat (30 * 16) @(negedge clk);
        #1;
        n_checks++; if (b8.rx_valid !== 1'b1) begin n_fail++; $display("FAIL brk_valid got %b want 1", b8.rx_valid); end
        n_checks++; if (b8.rx_data !== 8'h00) begin n_fail++; $display("FAIL brk_data got %h want 00", b8.rx_data); end
        n_checks++; if (b8.rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL brk_ferr got %b want 1", b8.rx_frame_err); end
        n_checks++; if (b8.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL brk_one_word got ovr %b want 0", b8.rx_overrun); end
        @(negedge clk); rx8 = 1'b1;
        repeat (40) @(posedge clk);
        accept8();
        rx_send(8, 'h5A, 1'b0);
        wait_rx8();
        n_checks++; if (b8.rx_data !== 8'h5A) begin n_fail++; $display("FAIL brk_after_data got %h want 5a", b8.rx_data); end
        n_checks++; if ({b8.rx_valid, b8.rx_frame_err, b8.rx_overrun} !== 3'b100) begin
            n_fail++; $display("FAIL brk_after_flags got %b want 100", {b8.rx_valid, b8.rx_frame_err, b8.rx_overrun}); end
        accept8();
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        @(negedge clk); b8.tx_data = d; b8.tx_valid = 1'b1;
        @(posedge clk); #1; b8.tx_valid = 1'b0;
        repeat (1 + 16 * 4 + 8) @(posedge clk); #1;
        n_checks++; if (tx8 !== d[3]) begin n_fail++; $display("FAIL mid_tx_bit3 got %b want %b", tx8, d[3]); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tx8 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx got %b want 1", tx8); end
        n_checks++; if (b8.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", b8.tx_ready); end
        n_checks++; if (b8.tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", b8.tx_busy); end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

`ifdef UART_CORE_LOOPBACK_EN
    task automatic test_loopback();
        int lows, t;
        lows = 0;
        @(negedge clk); lb8 = 1'b1;
        repeat (4) @(negedge clk);
        b8.tx_data = 8'hC3; b8.tx_valid = 1'b1;
        @(posedge clk); #1; b8.tx_valid = 1'b0;
        t = 0;
        while (b8.rx_valid !== 1'b1 && t < 300) begin
            @(posedge clk); #1; t++;
            if (tx8 !== 1'b1) lows++;
        end
        n_checks++; if (b8.rx_valid !== 1'b1) begin n_fail++; $display("FAIL lb_valid got %b want 1", b8.rx_valid); end
        n_checks++; if (b8.rx_data !== 8'hC3) begin n_fail++; $display("FAIL lb_data got %h want c3", b8.rx_data); end
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL lb_pin_low_cycles got %0d want 0", lows); end
        repeat (40) @(posedge clk);
        accept8();
        @(negedge clk); lb8 = 1'b0;
    endtask
`endif

    initial begin
        b8.tx_data = '0; b8.tx_valid = 1'b0; b8.rx_ready = 1'b0;
        b7.tx_data = '0; b7.tx_valid = 1'b0; b7.rx_ready = 1'b0;
        test_reset();
        test_tx();
        test_rx_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid_tx();
`ifdef UART_CORE_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end
endmodule
